// File: rtl/operand2_pipe.sv
// ============================================================================
// Module   : operand2_pipe
// Purpose  : Barrel-shifter operand-2 pipeline (LSL/LSR/ASR/ROR, immediate
//            bypass) with valid/ready handshaking, 1 or 2 register stages.
//            Optional feature: define OPERAND2_RRX_EN so immediate ROR #0 is RRX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand2_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         rm_value,
  input  logic [WIDTH-1:0]         rs_value,
  input  logic [$clog2(WIDTH)-1:0] imm_shamt,
  input  logic                     shift_reg,
  input  logic [1:0]               shift_type,
  input  logic [WIDTH-1:0]         ext_imm,
  input  logic                     alu_src,
  input  logic                     carry_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         src_b,
  output logic                     shift_carry
);

  localparam int         c_LW  = $clog2(WIDTH);
  localparam logic [8:0] c_W   = 9'(WIDTH);
  localparam logic [1:0] c_LSL = 2'b00;
  localparam logic [1:0] c_LSR = 2'b01;
  localparam logic [1:0] c_ASR = 2'b10;

  // Returns {carry_out, result}; amounts are 9 bits so n = WIDTH is representable.
  function automatic logic [WIDTH:0] f_shift(
    input logic [8:0]       amt,
    input logic [1:0]       typ,
    input logic             rrx,
    input logic [WIDTH-1:0] rm,
    input logic             cin
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] tmp;
    logic             co;
    logic             msb;
    logic [8:0]       rot;
    msb = rm[WIDTH-1];
    rot = {{(9-c_LW){1'b0}}, amt[c_LW-1:0]};
    res = rm;
    co  = cin;
    tmp = '0;
    if (rrx) begin
      res = {cin, rm[WIDTH-1:1]};
      co  = rm[0];
    end else if (amt != 9'd0) begin
      case (typ)
        c_LSL: begin
          if (amt < c_W) begin
            res = rm << amt;
            tmp = rm >> (c_W - amt);
            co  = tmp[0];
          end else begin
            res = '0;
            co  = (amt == c_W) ? rm[0] : 1'b0;
          end
        end
        c_LSR: begin
          if (amt < c_W) begin
            res = rm >> amt;
            tmp = rm >> (amt - 9'd1);
            co  = tmp[0];
          end else begin
            res = '0;
            co  = (amt == c_W) ? msb : 1'b0;
          end
        end
        c_ASR: begin
          if (amt < c_W) begin
            res = $unsigned($signed(rm) >>> amt);
            tmp = rm >> (amt - 9'd1);
            co  = tmp[0];
          end else begin
            res = {WIDTH{msb}};
            co  = msb;
          end
        end
        default: begin
          if (rot == 9'd0) begin
            res = rm;
            co  = msb;
          end else begin
            res = (rm >> rot) | (rm << (c_W - rot));
            tmp = rm >> (rot - 9'd1);
            co  = tmp[0];
          end
        end
      endcase
    end
    return {co, res};
  endfunction

  logic w_rrx_en;
`ifdef OPERAND2_RRX_EN
  assign w_rrx_en = 1'b1;
`else
  assign w_rrx_en = 1'b0;
`endif

  // Amount decode: immediate LSR/ASR #0 mean a full-width shift.
  logic [8:0] w_dec_amt;
  logic       w_dec_rrx;
  always_comb begin
    w_dec_rrx = 1'b0;
    if (shift_reg) begin
      w_dec_amt = {1'b0, rs_value[7:0]};
    end else begin
      w_dec_amt = 9'(imm_shamt);
      if (imm_shamt == '0) begin
        if (shift_type == c_LSR || shift_type == c_ASR) begin
          w_dec_amt = c_W;
        end else if (shift_type != c_LSL) begin
          w_dec_rrx = w_rrx_en;
        end
      end
    end
  end

  generate
    if (WIDTH > 8) begin : g_rs_hi
      logic w_unused_rs;
      assign w_unused_rs = ^rs_value[WIDTH-1:8];
    end
  endgenerate

  logic             r_out_valid;
  logic [WIDTH-1:0] r_src_b;
  logic             r_carry;
  logic             w_out_free;

  assign w_out_free  = !r_out_valid || out_ready;
  assign out_valid   = r_out_valid;
  assign src_b       = r_src_b;
  assign shift_carry = r_carry;

  generate
    if (STAGES == 2) begin : g_two
      logic             r_s1_valid;
      logic [8:0]       r_s1_amt;
      logic [1:0]       r_s1_type;
      logic             r_s1_rrx;
      logic [WIDTH-1:0] r_s1_rm;
      logic [WIDTH-1:0] r_s1_ext;
      logic             r_s1_alu;
      logic             r_s1_cin;
      logic [WIDTH:0]   w_s1_res;

      assign in_ready = !r_s1_valid || w_out_free;
      assign w_s1_res = r_s1_alu ? {r_s1_cin, r_s1_ext}
                                 : f_shift(r_s1_amt, r_s1_type, r_s1_rrx, r_s1_rm, r_s1_cin);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_s1_valid <= 1'b0;
          r_s1_amt   <= '0;
          r_s1_type  <= '0;
          r_s1_rrx   <= 1'b0;
          r_s1_rm    <= '0;
          r_s1_ext   <= '0;
          r_s1_alu   <= 1'b0;
          r_s1_cin   <= 1'b0;
        end else if (in_ready) begin
          r_s1_valid <= in_valid;
          if (in_valid) begin
            r_s1_amt  <= w_dec_amt;
            r_s1_type <= shift_type;
            r_s1_rrx  <= w_dec_rrx;
            r_s1_rm   <= rm_value;
            r_s1_ext  <= ext_imm;
            r_s1_alu  <= alu_src;
            r_s1_cin  <= carry_in;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_out_valid <= 1'b0;
          r_src_b     <= '0;
          r_carry     <= 1'b0;
        end else if (w_out_free) begin
          r_out_valid <= r_s1_valid;
          if (r_s1_valid) begin
            {r_carry, r_src_b} <= w_s1_res;
          end
        end
      end
    end else begin : g_one
      logic [WIDTH:0] w_res;

      assign in_ready = w_out_free;
      assign w_res    = alu_src ? {carry_in, ext_imm}
                                : f_shift(w_dec_amt, shift_type, w_dec_rrx, rm_value, carry_in);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_out_valid <= 1'b0;
          r_src_b     <= '0;
          r_carry     <= 1'b0;
        end else if (w_out_free) begin
          r_out_valid <= in_valid;
          if (in_valid) begin
            {r_carry, r_src_b} <= w_res;
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_operand2_pipe.sv
// ============================================================================
// Module   : tb_operand2_pipe
// Purpose  : Directed self-checking bench for operand2_pipe, WIDTH=32,
//            one instance with STAGES=1 and one with STAGES=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand2_pipe;

  localparam logic [1:0] c_LSL = 2'b00;
  localparam logic [1:0] c_LSR = 2'b01;
  localparam logic [1:0] c_ASR = 2'b10;
  localparam logic [1:0] c_ROR = 2'b11;
`ifdef OPERAND2_RRX_EN
  localparam logic [31:0] c_RRX_B = 32'h8000_0001;
`else
  localparam logic [31:0] c_RRX_B = 32'h0000_0003;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        iv1, iv2, ir1, ir2, ov1, ov2, or2;
  logic [31:0] rm, rs, ext, sb1, sb2;
  logic [4:0]  imm;
  logic [1:0]  typ;
  logic        sreg, alu, cin, sc1, sc2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  operand2_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .rm_value(rm), .rs_value(rs), .imm_shamt(imm), .shift_reg(sreg),
    .shift_type(typ), .ext_imm(ext), .alu_src(alu), .carry_in(cin),
    .out_valid(ov1), .out_ready(1'b1), .src_b(sb1), .shift_carry(sc1)
  );

  operand2_pipe #(.WIDTH(32), .STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2),
    .rm_value(rm), .rs_value(rs), .imm_shamt(imm), .shift_reg(sreg),
    .shift_type(typ), .ext_imm(ext), .alu_src(alu), .carry_in(cin),
    .out_valid(ov2), .out_ready(or2), .src_b(sb2), .shift_carry(sc2)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_req(input logic s, input logic [1:0] t, input logic [4:0] i,
                         input logic [31:0] r_s, input logic [31:0] r_m,
                         input logic [31:0] e, input logic a, input logic c);
    sreg = s; typ = t; imm = i; rs = r_s; rm = r_m; ext = e; alu = a; cin = c;
  endtask

  // Called just after a falling edge; the request transfers on the next rising edge.
  task automatic run_s1(input string tag, input logic s, input logic [1:0] t,
                        input logic [4:0] i, input logic [31:0] r_s, input logic [31:0] r_m,
                        input logic [31:0] e, input logic a, input logic c,
                        input logic [31:0] exp_b, input logic exp_c);
    set_req(s, t, i, r_s, r_m, e, a, c);
    iv1 = 1'b1;
    check_val({tag, "_in_ready"}, 64'(ir1), 64'd1);
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    check_val({tag, "_out_valid"}, 64'(ov1), 64'd1);
    check_val({tag, "_src_b"}, 64'(sb1), 64'(exp_b));
    check_val({tag, "_carry"}, 64'(sc1), 64'(exp_c));
    @(negedge clk);
  endtask

  logic        q_sreg [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0]  q_typ  [4] = '{c_LSL, c_LSR, c_ROR, c_LSL};
  logic [4:0]  q_imm  [4] = '{5'd1, 5'd1, 5'd0, 5'd0};
  logic [31:0] q_rs   [4] = '{32'h0, 32'h0, 32'h2, 32'h0};
  logic [31:0] q_rm   [4] = '{32'h8000_0001, 32'h3, 32'hC, 32'h55};
  logic        q_cin  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [32:0] q_exp  [4] = '{{1'b1, 32'h2}, {1'b1, 32'h1}, {1'b0, 32'h3}, {1'b1, 32'h55}};

  initial begin
    int          idx, popped;
    logic        held, saw_stall, acc, any_ov;
    logic [32:0] hold_v;

    reset = 1'b1; iv1 = 1'b0; iv2 = 1'b0; or2 = 1'b1;
    set_req(1'b0, c_LSL, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check_val("rst_ov1", 64'(ov1), 64'd0);
    check_val("rst_ir1", 64'(ir1), 64'd1);
    check_val("rst_sb1", 64'(sb1), 64'd0);
    check_val("rst_sc1", 64'(sc1), 64'd0);
    check_val("rst_ov2", 64'(ov2), 64'd0);
    check_val("rst_ir2", 64'(ir2), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Single-stage vectors; the first one transfers on the first edge after reset.
    run_s1("lsl_imm1",   1'b0, c_LSL, 5'd1, 32'h0,   32'h8000_0001, 32'h0, 1'b0, 1'b0, 32'h0000_0002, 1'b1);
    run_s1("lsr_r32",    1'b1, c_LSR, 5'd0, 32'h20,  32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1);
    run_s1("lsr_r33",    1'b1, c_LSR, 5'd0, 32'h21,  32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0);
    run_s1("ror_r64",    1'b1, c_ROR, 5'd0, 32'h40,  32'h8000_0001, 32'h0, 1'b0, 1'b0, 32'h8000_0001, 1'b1);
    run_s1("asr_imm0",   1'b0, c_ASR, 5'd0, 32'h0,   32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    run_s1("ror_imm0",   1'b0, c_ROR, 5'd0, 32'h0,   32'h0000_0003, 32'h0, 1'b0, 1'b1, c_RRX_B,       1'b1);
    run_s1("lsl_r0",     1'b1, c_LSL, 5'd0, 32'h0,   32'h1234_5678, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
    run_s1("lsl_imm0",   1'b0, c_LSL, 5'd0, 32'h0,   32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0, 32'hA5A5_A5A5, 1'b0);
    run_s1("lsl_r32",    1'b1, c_LSL, 5'd0, 32'h20,  32'h0000_0001, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1);
    run_s1("lsl_r33",    1'b1, c_LSL, 5'd0, 32'h21,  32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0,         1'b0);
    run_s1("lsl_imm4",   1'b0, c_LSL, 5'd4, 32'h0,   32'hF000_000F, 32'h0, 1'b0, 1'b0, 32'h0000_00F0, 1'b1);
    run_s1("lsr_imm8",   1'b0, c_LSR, 5'd8, 32'h0,   32'h0000_01FF, 32'h0, 1'b0, 1'b0, 32'h0000_0001, 1'b1);
    run_s1("lsr_imm0",   1'b0, c_LSR, 5'd0, 32'h0,   32'h8000_0001, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1);
    run_s1("asr_imm4",   1'b0, c_ASR, 5'd4, 32'h0,   32'h8000_0010, 32'h0, 1'b0, 1'b1, 32'hF800_0001, 1'b0);
    run_s1("asr_r255",   1'b1, c_ASR, 5'd0, 32'hFF,  32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0,         1'b0);
    run_s1("ror_r36",    1'b1, c_ROR, 5'd0, 32'h24,  32'h0000_000F, 32'h0, 1'b0, 1'b0, 32'hF000_0000, 1'b1);
    run_s1("rs_hi_ign",  1'b1, c_LSL, 5'd0, 32'h100, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 32'h0000_0001, 1'b1);
    run_s1("alu_bypass", 1'b1, c_LSL, 5'd0, 32'h4,   32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Two-stage latency with no backpressure.
    set_req(1'b0, c_LSL, 5'd1, 32'h0, 32'h8000_0001, 32'h0, 1'b0, 1'b0);
    iv2 = 1'b1;
    check_val("s2_in_ready", 64'(ir2), 64'd1);
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    check_val("s2_lat_early", 64'(ov2), 64'd0);
    @(posedge clk);
    #1;
    check_val("s2_lat_valid", 64'(ov2), 64'd1);
    check_val("s2_lat_res", {sc2, sb2}, {1'b1, 32'h2});
    @(posedge clk);
    #1;
    check_val("s2_drained", 64'(ov2), 64'd0);

    // Four back-to-back requests, consumer stalls during iterations 3..5.
    idx = 0; popped = 0; held = 1'b0; saw_stall = 1'b0; hold_v = '0;
    for (int k = 0; k < 40 && popped < 4; k++) begin
      or2 = !(k >= 3 && k <= 5);
      if (idx < 4) begin
        set_req(q_sreg[idx], q_typ[idx], q_imm[idx], q_rs[idx], q_rm[idx], 32'h0, 1'b0, q_cin[idx]);
        iv2 = 1'b1;
      end else begin
        iv2 = 1'b0;
        cin = 1'b0;
      end
      @(negedge clk);
      acc = ir2 && iv2;
      if (ov2) begin
        if (held) check_val("stall_hold", {sc2, sb2}, hold_v);
        if (or2) begin
          check_val("s2_order", {sc2, sb2}, q_exp[popped]);
          popped++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          hold_v = {sc2, sb2};
          if (!ir2) saw_stall = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    iv2 = 1'b0;
    check_val("s2_count", 64'(popped), 64'd4);
    check_val("s2_accepted", 64'(idx), 64'd4);
    check_val("s2_inready_low", 64'(saw_stall), 64'd1);
    any_ov = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      any_ov = any_ov | ov2;
    end
    check_val("s2_no_dup", 64'(any_ov), 64'd0);

    // Fill both stages, then reset asynchronously between clock edges.
    @(posedge clk);
    #1;
    or2 = 1'b0;
    set_req(1'b0, c_LSL, 5'd1, 32'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
    iv2 = 1'b1;
    @(posedge clk);
    #1;
    rm = 32'h0000_0002;
    @(posedge clk);
    #1;
    iv2 = 1'b0;
    check_val("pre_rst_full", 64'(ov2), 64'd1);
    check_val("pre_rst_ir", 64'(ir2), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_ov2", 64'(ov2), 64'd0);
    check_val("arst_ir2", 64'(ir2), 64'd1);
    check_val("arst_sb2", 64'(sb2), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    or2 = 1'b1;
    any_ov = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      any_ov = any_ov | ov2;
    end
    check_val("rst_no_stale", 64'(any_ov), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand2_pipe.md
OPERAND2_PIPE -- requirements
Module: operand2_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (power of two, 8..64).
REQ-002 SHALL have parameter STAGES, default 1, pipeline depth; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when in_valid high.
REQ-007 SHALL have port rm_value  input  WIDTH  register operand to be shifted.
REQ-008 SHALL have port rs_value  input  WIDTH  shift-amount register; only bits [7:0] used.
REQ-009 SHALL have port imm_shamt  input  log2(WIDTH)  immediate shift amount.
REQ-010 SHALL have port shift_reg  input  1  1 = amount from rs_value, 0 = from imm_shamt.
REQ-011 SHALL have port shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-012 SHALL have port ext_imm  input  WIDTH  extended immediate.
REQ-013 SHALL have port alu_src  input  1  1 = result is ext_imm unshifted, 0 = shifted rm_value.
REQ-014 SHALL have port carry_in  input  1  current C flag.
REQ-015 SHALL have port out_valid  output  1  result present.
REQ-016 SHALL have port out_ready  input  1  consumer accepts result.
REQ-017 SHALL have port src_b  output  WIDTH  operand-2 result.
REQ-018 SHALL have port shift_carry  output  1  shifter carry-out.

Function
REQ-019 Transfer SHALL occur on a rising edge when valid and ready are both high, on each side independently.
REQ-020 Each stage SHALL be a one-entry register accepting new data when empty or when its content leaves the same cycle; throughput one result per cycle with out_ready held high.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid high with no backpressure.
REQ-022 STAGES=2: stage 1 SHALL register the decoded amount and operands, stage 2 SHALL register the shift result.
REQ-023 in_ready SHALL be a function of stage occupancy and out_ready only, never of in_valid.
REQ-024 While out_valid high and out_ready low, src_b and shift_carry SHALL hold stable.
REQ-025 Amount = 0 (register or decoded immediate) SHALL give src_b = rm_value, shift_carry = carry_in.
REQ-026 LSL n, 0<n<WIDTH: src_b = rm_value<<n, carry = rm_value[WIDTH-n]; n=WIDTH: 0, carry rm_value[0]; n>WIDTH: 0, carry 0.
REQ-027 LSR n, 0<n<WIDTH: logical right, carry = rm_value[n-1]; n=WIDTH: 0, carry MSB; n>WIDTH: 0, carry 0.
REQ-028 ASR n, 0<n<WIDTH: arithmetic right, carry = rm_value[n-1]; n>=WIDTH: all bits = MSB, carry = MSB.
REQ-029 ROR register n>0: rotate by n mod WIDTH; if n mod WIDTH = 0, src_b = rm_value, carry = MSB; else carry = rm_value[(n-1) mod WIDTH].
REQ-030 Immediate LSR #0 and ASR #0 SHALL decode as amount WIDTH; immediate LSL #0 is amount 0.
REQ-031 alu_src=1 SHALL give src_b = ext_imm, shift_carry = carry_in, shifter bypassed.
REQ-032 carry_in SHALL be sampled with the request, not at output time.

Reset
REQ-033 Reset asserted SHALL immediately clear all stage-valid bits: out_valid=0, in_ready=1.
REQ-034 During reset src_b and shift_carry SHALL be 0.
REQ-035 Reset mid-operation SHALL discard in-flight results; none SHALL appear after deassertion.
REQ-036 First transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-037 With OPERAND2_RRX_EN defined, immediate ROR #0 SHALL be RRX: src_b = {carry_in, rm_value[WIDTH-1:1]}, carry = rm_value[0].
REQ-038 Without OPERAND2_RRX_EN, immediate ROR #0 SHALL be amount 0 per REQ-025; all other behaviour identical.

Verification
REQ-039 WIDTH=32, STAGES=1: rm=0x80000001, imm LSL #1, carry_in=0 -> src_b=0x00000002, carry=1, out_valid one cycle after transfer.
REQ-040 Register LSR, rs=0x00000020, rm=0x80000000 -> src_b=0, carry=1; rs=0x00000021 -> src_b=0, carry=0.
REQ-041 Register ROR, rs=0x40, rm=0x80000001 -> src_b=0x80000001, carry=1; imm ASR #0, rm=0x80000000 -> src_b=0xFFFFFFFF, carry=1.
REQ-042 STAGES=2, 4 back-to-back requests, out_ready low cycles 3-5 -> in_ready low once both stages full, results in order, no loss or duplication, src_b stable while stalled.
REQ-043 Reset pulse with 2 results in flight -> out_valid 0 asynchronously, no stale result after release.
REQ-044 Imm ROR #0, rm=0x00000003, carry_in=1 -> with OPERAND2_RRX_EN src_b=0x80000001, carry=1; without, src_b=0x00000003, carry=1.
